// File: rtl/act_pkg.sv
// Shared definitions for the activation pipeline: mode encoding and default widths.
package act_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLAMP  = 2'd3
    } act_mode_e;

    localparam int DATA_W_DEF  = 8;
    localparam int ALPHA_W_DEF = 8;
    localparam int FRAC_W_DEF  = 6;
    localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/act_scale_sat.sv
// Leak scaling: signed sample times unsigned fixed-point alpha, then round-half-up,
// arithmetic shift and saturation back to the sample width. Purely combinational.
module act_scale_sat
    import act_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ALPHA_W = ALPHA_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF
) (
    input  logic [DATA_W-1:0]       mul_x,
    input  logic [ALPHA_W-1:0]      mul_alpha,
    output logic [DATA_W+ALPHA_W:0] mul_prod,
    input  logic [DATA_W+ALPHA_W:0] rnd_prod,
    output logic [DATA_W-1:0]       rnd_data,
    output logic                    rnd_sat
);

    localparam int PROD_W = DATA_W + ALPHA_W + 1;

    localparam logic signed [PROD_W:0] ONE    = {{PROD_W{1'b0}}, 1'b1};
    localparam logic signed [PROD_W:0] HALF   = ONE <<< (FRAC_W - 1);
    localparam logic signed [PROD_W:0] SAT_HI = (ONE <<< (DATA_W - 1)) - ONE;
    localparam logic signed [PROD_W:0] SAT_LO = -(ONE <<< (DATA_W - 1));

    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W:0]   rnd_sum;
    logic signed [PROD_W:0]   rnd_shift;

    // alpha is unsigned, so it is zero-extended before the signed multiply.
    assign x_ext    = {{(PROD_W - DATA_W){mul_x[DATA_W-1]}}, mul_x};
    assign a_ext    = {{(PROD_W - ALPHA_W){1'b0}}, mul_alpha};
    assign mul_prod = x_ext * a_ext;

    // NOTE: every combinationally driven signal gets a default first so no path infers a latch.
    always_comb begin
        rnd_sum   = $signed({rnd_prod[PROD_W-1], rnd_prod}) + HALF;
        rnd_shift = rnd_sum >>> FRAC_W;
        rnd_data  = rnd_shift[DATA_W-1:0];
        rnd_sat   = 1'b0;
        if (rnd_shift > SAT_HI) begin
            rnd_data = SAT_HI[DATA_W-1:0];
            rnd_sat  = 1'b1;
        end else if (rnd_shift < SAT_LO) begin
            rnd_data = SAT_LO[DATA_W-1:0];
            rnd_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage activation pipeline (bypass / ReLU / leaky ReLU / clamped ReLU) with
// valid/ready on both sides and a saturating count of clipped outputs.
module activation_pipe
    import act_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ALPHA_W = ALPHA_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         cfg_mode,
    input  logic [ALPHA_W-1:0] cfg_alpha,
    input  logic [DATA_W-1:0]  cfg_clip,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_sat,
    input  logic               sat_clr,
    output logic [CNT_W-1:0]   sat_count
);

    localparam int PROD_W = DATA_W + ALPHA_W + 1;

    logic              s1_valid_q,  s1_valid_d;
    act_mode_e         s1_mode_q,   s1_mode_d;
    logic [DATA_W-1:0] s1_data_q,   s1_data_d;
    logic [DATA_W-1:0] s1_clip_q,   s1_clip_d;
    logic [PROD_W-1:0] s1_prod_q,   s1_prod_d;
    logic              s2_valid_q,  s2_valid_d;
    logic [DATA_W-1:0] s2_data_q,   s2_data_d;
    logic              s2_sat_q,    s2_sat_d;
    logic [CNT_W-1:0]  sat_count_q, sat_count_d;

    logic              s1_load, s2_load, in_fire, out_fire;
    logic [PROD_W-1:0] mul_prod;
    logic [DATA_W-1:0] leak_data, res_data;
    logic              leak_sat,  res_sat;

    act_scale_sat #(
        .DATA_W  (DATA_W),
        .ALPHA_W (ALPHA_W),
        .FRAC_W  (FRAC_W)
    ) u_scale (
        .mul_x     (in_data),
        .mul_alpha (cfg_alpha),
        .mul_prod  (mul_prod),
        .rnd_prod  (s1_prod_q),
        .rnd_data  (leak_data),
        .rnd_sat   (leak_sat)
    );

    // in_ready is held low by rst_n itself, so it rises with reset release and the first edge can accept.
    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        in_ready = rst_n && s1_load;
        in_fire  = in_valid && in_ready;
        out_fire = s2_valid_q && out_ready;
    end

    always_comb begin
        res_data = s1_data_q;
        res_sat  = 1'b0;
        case (s1_mode_q)
            ACT_BYPASS: ;
            ACT_RELU: begin
                if (s1_data_q[DATA_W-1]) res_data = '0;
            end
            ACT_LEAKY: begin
                if (s1_data_q[DATA_W-1]) begin
                    res_data = leak_data;
                    res_sat  = leak_sat;
                end
            end
            ACT_CLAMP: begin
                if (s1_data_q[DATA_W-1])                          res_data = '0;
                else if ($signed(s1_data_q) > $signed(s1_clip_q)) res_data = s1_clip_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_mode_d   = s1_mode_q;
        s1_data_d   = s1_data_q;
        s1_clip_d   = s1_clip_q;
        s1_prod_d   = s1_prod_q;
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_sat_d    = s2_sat_q;
        sat_count_d = sat_count_q;

        if (s1_load) s1_valid_d = in_fire;
        // Config is captured alongside the sample so later cfg changes never touch it.
        if (in_fire) begin
            s1_mode_d = act_mode_e'(cfg_mode);
            s1_data_d = in_data;
            s1_clip_d = cfg_clip;
            s1_prod_d = mul_prod;
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = res_data;
                s2_sat_d  = res_sat;
            end
        end

        if (sat_clr)
            sat_count_d = '0;
        else if (out_fire && s2_sat_q && !(&sat_count_q))
            sat_count_d = sat_count_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    // NOTE: datapath flops are reset as well; it is a handful of bits and keeps out_data at 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= ACT_BYPASS;
            s1_data_q   <= '0;
            s1_clip_q   <= '0;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_sat_q    <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_data_q   <= s1_data_d;
            s1_clip_q   <= s1_clip_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_sat_q    <= s2_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_sat   = s2_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_activation_pipe.sv
// Scoreboard bench for activation_pipe: the driver pushes expected results on each
// input handshake, an independent monitor pops and compares on each output handshake.
module tb_activation_pipe;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int FW    = 6;
    localparam int CW    = 16;
    localparam int SCALE = 1 << FW;
    localparam int HALF  = SCALE / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    cfg_mode;
    logic [AW-1:0] cfg_alpha;
    logic [DW-1:0] cfg_clip;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sat;
    logic          sat_clr;
    logic [CW-1:0] sat_count;

    always #5 clk = ~clk;

    activation_pipe #(
        .DATA_W  (DW),
        .ALPHA_W (AW),
        .FRAC_W  (FW),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_mode  (cfg_mode),
        .cfg_alpha (cfg_alpha),
        .cfg_clip  (cfg_clip),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sat;
        int            acc_edge;
        bit            timed;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   edge_cnt   = 0;
    int   model_cnt  = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, want, $time);
        end
    endtask

    // Reference activation from plain integer arithmetic; returns {sat, y}.
    function automatic logic [DW:0] ref_act(input int mode, input int x, input int alpha, input int clip);
        int   y;
        int   t;
        logic sat;
        sat = 1'b0;
        case (mode)
            0:       y = x;
            1:       y = (x < 0) ? 0 : x;
            3:       y = (x < 0) ? 0 : ((x > clip) ? clip : x);
            default: begin
                if (x >= 0) y = x;
                else begin
                    t = x * alpha + HALF;
                    y = (t >= 0) ? t / SCALE : -((-t + SCALE - 1) / SCALE);
                    if (y < -(1 << (DW - 1)))    begin y = -(1 << (DW - 1));    sat = 1'b1; end
                    if (y > (1 << (DW - 1)) - 1) begin y = (1 << (DW - 1)) - 1; sat = 1'b1; end
                end
            end
        endcase
        return {sat, DW'(y)};
    endfunction

    task automatic push_exp(input logic [DW-1:0] d, input logic s, input bit timed);
        exp_t e;
        e.data     = d;
        e.sat      = s;
        e.acc_edge = edge_cnt + 1;
        e.timed    = timed;
        sb.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input int mode, input int alpha, input int clip, input int x,
                        input bit use_exp, input logic [DW-1:0] exp_d, input logic exp_s,
                        input bit timed, input bit rand_cfg);
        int          waited;
        logic [DW:0] r;
        waited    = 0;
        in_valid  = 1'b1;
        cfg_mode  = 2'(mode);
        cfg_alpha = AW'(alpha);
        cfg_clip  = DW'(clip);
        in_data   = DW'(x);
        forever begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (rand_cfg)   cfg_mode  = 2'($urandom_range(0, 3));
            #1;
            check("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() < 2) || out_ready});
            if (in_ready) begin
                if (use_exp) push_exp(exp_d, exp_s, timed);
                else begin
                    r = ref_act(int'(cfg_mode), int'($signed(in_data)), int'(cfg_alpha),
                                int'($signed(cfg_clip)));
                    push_exp(r[DW-1:0], r[DW], timed);
                end
                break;
            end
            waited++;
            if (waited > 200) begin
                check("accept_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int w;
        w          = 0;
        in_valid   = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            w++;
            if (w > 50) begin
                check("drain_timeout", sb.size(), 32'd0);
                break;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: output ordering, stability under stall, and the sat_count model.
    exp_t          mon_e;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_sat;
    bit            sat_inc;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
            model_cnt  = 0;
        end else begin
            sat_inc = 1'b0;
            check("sat_count", {16'd0, sat_count}, model_cnt);
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {24'd0, out_data}, {24'd0, prev_data});
                check("stall_sat", {31'd0, out_sat}, {31'd0, prev_sat});
            end
            if (out_valid && out_ready) begin
                check("output_expected", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, mon_e.data});
                    check("out_sat", {31'd0, out_sat}, {31'd0, mon_e.sat});
                    if (mon_e.timed) check("latency", edge_cnt + 1 - mon_e.acc_edge, 32'd2);
                    sat_inc = mon_e.sat && (model_cnt < (1 << CW) - 1);
                end
            end
            if (sat_clr)      model_cnt = 0;
            else if (sat_inc) model_cnt = model_cnt + 1;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_sat   = out_sat;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_out;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        cfg_mode  = '0;
        cfg_alpha = '0;
        cfg_clip  = '0;
        in_data   = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_sat", {31'd0, out_sat}, 32'd0);
        check("rst_sat_count", {16'd0, sat_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Leaky ReLU rounding stream, first result timed.
        send(2, 8'h03, 0, -128, 1, 8'hFA, 1'b0, 1, 0);
        send(2, 8'h03, 0, -1,   1, 8'h00, 1'b0, 0, 0);
        send(2, 8'h03, 0, 0,    1, 8'h00, 1'b0, 0, 0);
        send(2, 8'h03, 0, 127,  1, 8'h7F, 1'b0, 0, 0);
        drain();

        send(2, 8'hFF, 0, -128, 1, 8'h80, 1'b1, 0, 0);
        drain();
        check("sat_count_one", {16'd0, sat_count}, 32'd1);

        send(3, 0, 8'h20, 8'h50, 1, 8'h20, 1'b0, 0, 0);
        send(3, 0, 8'h20, 8'h10, 1, 8'h10, 1'b0, 0, 0);
        send(3, 0, 8'h20, -5,    1, 8'h00, 1'b0, 0, 0);
        send(1, 0, 8'h20, -5,    1, 8'h00, 1'b0, 0, 0);
        send(0, 0, 8'h20, -5,    1, 8'hFB, 1'b0, 0, 0);
        drain();

        // Both stages full with out_ready low must refuse input.
        out_ready = 1'b0;
        send(0, 0, 0, 8'h01, 1, 8'h01, 1'b0, 0, 0);
        send(0, 0, 0, 8'h02, 1, 8'h02, 1'b0, 0, 0);
        in_valid = 1'b1;
        in_data  = 8'h03;
        #1;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++)
            send(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 255)) - 128, 0, 8'h00, 1'b0, 0, 1);
        drain();

        // Counter saturation: clear, then one more saturating sample than the counter can hold.
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        for (int i = 0; i < (1 << CW); i++)
            send(2, 8'hFF, 0, -128, 1, 8'h80, 1'b1, 0, 0);
        drain();
        check("sat_count_hold", {16'd0, sat_count}, 32'h0000_FFFF);

        send(2, 8'hFF, 0, -128, 1, 8'h80, 1'b1, 0, 0);
        in_valid = 1'b0;
        got_out  = 1'b0;
        for (int i = 0; i < 10 && !got_out; i++) begin
            #1;
            if (out_valid) begin
                got_out = 1'b1;
                sat_clr = 1'b1;
            end
            @(negedge clk);
        end
        sat_clr = 1'b0;
        check("clr_saw_output", {31'd0, got_out}, 32'd1);
        check("sat_clr_override", {16'd0, sat_count}, 32'd0);
        drain();

        // Reset with two samples in flight.
        out_ready = 1'b0;
        send(0, 0, 0, 8'h11, 1, 8'h11, 1'b0, 0, 0);
        send(0, 0, 0, 8'h22, 1, 8'h22, 1'b0, 0, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", {24'd0, out_data}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("midrst_release_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("no_stale_output", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        send(3, 0, 8'h40, 8'h55, 1, 8'h40, 1'b0, 0, 0);
        drain();

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/activation_pipe.md
ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 The block SHALL expose parameters, one per line: name, default, meaning:
- DATA_W, 8, signed sample width (two's complement)
- ALPHA_W, 8, unsigned leak-coefficient width
- FRAC_W, 6, fractional bits of cfg_alpha (alpha = cfg_alpha / 2^FRAC_W)
- CNT_W, 16, saturation-counter width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- cfg_mode, in, 2, 0 bypass, 1 ReLU, 2 leaky ReLU, 3 clamped ReLU
- cfg_alpha, in, ALPHA_W, leak coefficient, unsigned fixed point
- cfg_clip, in, DATA_W, positive clamp limit for mode 3, signed, >= 0
- in_valid, in, 1, input sample valid
- in_ready, out, 1, block accepts sample this cycle
- in_data, in, DATA_W, signed input sample
- out_valid, out, 1, output sample valid
- out_ready, in, 1, downstream accepts output
- out_data, out, DATA_W, signed result
- out_sat, out, 1, result of this sample was saturated
- sat_clr, in, 1, synchronous clear of sat_count
- sat_count, out, CNT_W, count of saturated samples delivered
REQ-003 The block SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n).

Function
REQ-004 Transfer SHALL occur on a rising edge where valid and ready are both high, on either port.
REQ-005 The datapath SHALL be a two-stage pipeline: S1 registers the sample, cfg_mode and cfg_clip and the product in_data*cfg_alpha (signed, DATA_W+ALPHA_W+1 bits); S2 registers the rounded, saturated result.
REQ-006 Latency from input handshake to out_valid SHALL be 2 cycles; throughput SHALL be 1 sample/cycle while out_ready=1.
REQ-007 S2 SHALL load when it is empty or out_ready=1; S1 SHALL load when it is empty or S2 loads; in_ready SHALL equal the S1 load condition (a combinational path from out_ready is permitted).
REQ-008 Under backpressure, out_data, out_sat and out_valid SHALL hold stable, and no sample SHALL be dropped or duplicated.
REQ-009 cfg_* SHALL be sampled per sample at input handshake; a config change SHALL NOT affect samples already in flight.
REQ-010 Mode 0: y = x. Mode 1: y = x if x >= 0, else 0. Mode 3: y = min(x, cfg_clip) if x >= 0, else 0.
REQ-011 Mode 2: y = x if x >= 0; else y = (x*alpha + 2^(FRAC_W-1)) >>> FRAC_W (arithmetic shift, round half toward +inf).
REQ-012 The mode 2 negative result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat=1 only when clipping occurred; out_sat SHALL be 0 in modes 0, 1 and 3, including mode 3 clamping.
REQ-013 sat_count SHALL increment on each output handshake with out_sat=1, SHALL saturate at all-ones (no wrap), and on sat_clr SHALL go to 0, with sat_clr overriding a simultaneous increment.

Reset
REQ-014 While rst_n=0: S1/S2 valid=0, out_valid=0, out_data=0, out_sat=0, sat_count=0, in_ready=0.
REQ-015 Assertion of rst_n mid-operation SHALL discard all in-flight samples; after deassertion, in_ready SHALL be 1 on the first clock edge.

Structure
REQ-016 The shared package act_pkg SHALL hold the mode encoding type (ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLAMP) and the default parameter constants.
REQ-017 Multiply-round-saturate SHALL be a sub-module, act_scale_sat, parameterised by DATA_W/ALPHA_W/FRAC_W; handshake and counter logic SHALL stay in activation_pipe.

Verification (defaults DATA_W=8, FRAC_W=6)
REQ-018 Mode 2, alpha=0x03, out_ready=1, stream -128, -1, 0, 127 -> outputs 0xFA, 0x00, 0x00, 0x7F, first output 2 cycles after first accept, out_sat=0 throughout.
REQ-019 Mode 2, alpha=0xFF, x=-128 -> out_data=0x80, out_sat=1, sat_count increments by 1.
REQ-020 Mode 3, clip=0x20, x = 0x50, 0x10, -5 -> 0x20, 0x10, 0x00; mode 1, x=-5 -> 0x00; mode 0, x=-5 -> 0xFB.
REQ-021 Continuous input with random out_ready (50%) and cfg_mode toggled every cycle -> output sequence equals reference-model order; outputs stable while stalled; in_ready=0 when both stages are full and out_ready=0.
REQ-022 sat_count preloaded to 0xFFFF by saturating samples plus one more -> holds 0xFFFF; sat_clr coincident with a saturated output -> 0.
REQ-023 rst_n pulsed low with 2 samples in flight -> out_valid=0 immediately, no stale output after release, next accepted sample correct.
